// File: rtl/ram16_vec_reducer.sv
// Snapshots NUM_WORDS parallel RAM words on start, then folds one per cycle into a signed sum.
// Optional max/argmax tracking is built only when REDUCER_MAX_EN is defined.
module ram16_vec_reducer #(
    parameter  int WORD_WIDTH = 16,
    parameter  int NUM_WORDS  = 32,
    localparam int SUM_WIDTH  = WORD_WIDTH + $clog2(NUM_WORDS),
    localparam int IDX_WIDTH  = $clog2(NUM_WORDS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0] words_i,
    input  logic                            start_i,
    output logic                            busy_o,
    output logic                            result_valid_o,
    input  logic                            result_ready_i,
    output logic [SUM_WIDTH-1:0]            sum_o,
    output logic [WORD_WIDTH-1:0]           max_o,
    output logic [IDX_WIDTH-1:0]            max_idx_o
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [SUM_WIDTH-1:0]   acc_q, acc_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic [SUM_WIDTH-1:0]   sum_q, sum_d;
    logic [WORD_WIDTH-1:0]  snap_q [NUM_WORDS];
    logic [WORD_WIDTH-1:0]  snap_d [NUM_WORDS];
    logic [WORD_WIDTH-1:0]  cur_word;
    logic [SUM_WIDTH-1:0]   cur_word_ext;

`ifdef REDUCER_MAX_EN
    localparam logic [WORD_WIDTH-1:0] MOST_NEG = {1'b1, {(WORD_WIDTH-1){1'b0}}};

    logic [WORD_WIDTH-1:0]  run_max_q, run_max_d;
    logic [IDX_WIDTH-1:0]   run_idx_q, run_idx_d;
    logic [WORD_WIDTH-1:0]  max_q, max_d;
    logic [IDX_WIDTH-1:0]   max_idx_q, max_idx_d;
`endif

    assign cur_word     = snap_q[idx_q];
    assign cur_word_ext = {{(SUM_WIDTH-WORD_WIDTH){cur_word[WORD_WIDTH-1]}}, cur_word};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        sum_d   = sum_q;
        snap_d  = snap_q;
`ifdef REDUCER_MAX_EN
        run_max_d = run_max_q;
        run_idx_d = run_idx_q;
        max_d     = max_q;
        max_idx_d = max_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    for (int k = 0; k < NUM_WORDS; k++) begin
                        snap_d[k] = words_i[k*WORD_WIDTH +: WORD_WIDTH];
                    end
                    acc_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ACC;
`ifdef REDUCER_MAX_EN
                    run_max_d = MOST_NEG;
                    run_idx_d = '0;
`endif
                end
            end
            ACC: begin
                acc_d = acc_q + cur_word_ext;
`ifdef REDUCER_MAX_EN
                // Strict compare keeps the lowest index on ties.
                if ($signed(cur_word) > $signed(run_max_q)) begin
                    run_max_d = cur_word;
                    run_idx_d = idx_q;
                end
`endif
                idx_d = idx_q + IDX_WIDTH'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    sum_d   = acc_d;
                    valid_d = 1'b1;
                    state_d = DONE;
`ifdef REDUCER_MAX_EN
                    max_d     = run_max_d;
                    max_idx_d = run_idx_d;
`endif
                end
            end
            DONE: begin
                if (result_ready_i) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= '0;
`ifdef REDUCER_MAX_EN
            run_max_q <= '0;
            run_idx_q <= '0;
            max_q     <= '0;
            max_idx_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
`ifdef REDUCER_MAX_EN
            run_max_q <= run_max_d;
            run_idx_q <= run_idx_d;
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
`endif
        end
    end

    // Snapshot contents are don't-care after reset, so no reset is needed here.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign busy_o         = busy_q;
    assign result_valid_o = valid_q;
    assign sum_o          = sum_q;
`ifdef REDUCER_MAX_EN
    assign max_o     = max_q;
    assign max_idx_o = max_idx_q;
`else
    assign max_o     = '0;
    assign max_idx_o = '0;
`endif

endmodule

// File: tb/tb_ram16_vec_reducer.sv
// Scoreboard bench for ram16_vec_reducer: directed vectors push expectations,
// a negedge monitor pops and compares whenever result_valid_o is presented.
module tb_ram16_vec_reducer;

    localparam int W  = 16;
    localparam int N  = 32;
    localparam int SW = 21;
    localparam int IW = 5;

    typedef struct {
        logic [SW-1:0] sum;
        logic [W-1:0]  mx;
        logic [IW-1:0] idx;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*W-1:0]  words_i;
    logic            start_i;
    logic            busy_o;
    logic            result_valid_o;
    logic            result_ready_i;
    logic [SW-1:0]   sum_o;
    logic [W-1:0]    max_o;
    logic [IW-1:0]   max_idx_o;

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t cur;
    bit   holding = 1'b0;

    ram16_vec_reducer dut (
        .clk            (clk),
        .rst            (rst),
        .words_i        (words_i),
        .start_i        (start_i),
        .busy_o         (busy_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .sum_o          (sum_o),
        .max_o          (max_o),
        .max_idx_o      (max_idx_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] max_exp(input logic [W-1:0] m);
`ifdef REDUCER_MAX_EN
        return m;
`else
        return (m & 16'h0000);
`endif
    endfunction

    function automatic logic [IW-1:0] idx_exp(input logic [IW-1:0] i);
`ifdef REDUCER_MAX_EN
        return i;
`else
        return (i & 5'd0);
`endif
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per presented result, re-checked every cycle it is held.
    always @(negedge clk) begin
        if (rst) begin
            holding = 1'b0;
        end else if (result_valid_o) begin
            if (!holding) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_result: got valid sum %0h, expected no result", sum_o);
                end else begin
                    cur     = sb.pop_front();
                    holding = 1'b1;
                end
            end
            if (holding) begin
                check_output("sum_o", 32'(sum_o), 32'(cur.sum));
                check_output("max_o", 32'(max_o), 32'(cur.mx));
                check_output("max_idx_o", 32'(max_idx_o), 32'(cur.idx));
            end
        end else begin
            holding = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [N*W-1:0] w, input exp_t e, input bit push);
        words_i = w;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check_output("busy_after_start", 32'(busy_o), 32'd1);
        if (push) sb.push_back(e);
    endtask

    task automatic check_latency;
        repeat (N - 1) tick();
        check_output("valid_before_latency", 32'(result_valid_o), 32'd0);
        tick();
        check_output("valid_at_latency", 32'(result_valid_o), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!result_valid_o && n < budget) begin
            tick();
            n++;
        end
        check_output("valid_within_budget", 32'(result_valid_o), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [N*W-1:0] ramp;
        logic [N*W-1:0] mixed;
        logic [N*W-1:0] negs;
        exp_t e;

        for (int k = 0; k < N; k++) begin
            ramp[k*W +: W]  = 16'(k);
            negs[k*W +: W]  = 16'h8000;
            mixed[k*W +: W] = 16'h0001;
        end
        mixed[5*W +: W]  = 16'h7FFF;
        mixed[20*W +: W] = 16'h7FFF;

        rst            = 1'b1;
        start_i        = 1'b0;
        result_ready_i = 1'b0;
        words_i        = '0;
        repeat (3) tick();
        check_output("rst_busy", 32'(busy_o), 32'd0);
        check_output("rst_valid", 32'(result_valid_o), 32'd0);
        check_output("rst_sum", 32'(sum_o), 32'd0);
        check_output("rst_max", 32'(max_o), 32'd0);
        check_output("rst_idx", 32'(max_idx_o), 32'd0);
        rst = 1'b0;
        tick();

        // All zeros.
        result_ready_i = 1'b1;
        e = '{sum: 21'd0, mx: max_exp(16'h0000), idx: idx_exp(5'd0)};
        apply_stimulus('0, e, 1'b1);
        check_latency();
        tick();
        check_output("zeros_valid_one_cycle", 32'(result_valid_o), 32'd0);
        check_output("zeros_busy_cleared", 32'(busy_o), 32'd0);

        // Ramp 0..31: sum 496, max 31 at 31.
        e = '{sum: 21'd496, mx: max_exp(16'd31), idx: idx_exp(5'd31)};
        apply_stimulus(ramp, e, 1'b1);
        check_latency();
        tick();
        check_output("ramp_valid_one_cycle", 32'(result_valid_o), 32'd0);
        tick();
        check_output("ramp_hold_after_handshake", 32'(sum_o), 32'd496);

        // All most-negative: tie resolves to index 0.
        e = '{sum: 21'h100000, mx: max_exp(16'h8000), idx: idx_exp(5'd0)};
        apply_stimulus(negs, e, 1'b1);
        check_latency();
        tick();
        check_output("neg_valid_one_cycle", 32'(result_valid_o), 32'd0);

        // Two maxima, inputs scrambled and start pulsed during ACC, ready withheld.
        result_ready_i = 1'b0;
        e = '{sum: 21'd65564, mx: max_exp(16'h7FFF), idx: idx_exp(5'd5)};
        apply_stimulus(mixed, e, 1'b1);
        for (int i = 0; i < N - 1; i++) begin
            for (int k = 0; k < N; k++) words_i[k*W +: W] = 16'($urandom);
            start_i = (i % 2 == 0);
            tick();
        end
        start_i = 1'b0;
        wait_valid(5);
        for (int i = 0; i < 10; i++) begin
            start_i = (i == 3);
            tick();
            check_output("mixed_valid_held", 32'(result_valid_o), 32'd1);
        end
        result_ready_i = 1'b1;
        start_i        = 1'b1;
        tick();
        start_i = 1'b0;
        check_output("mixed_valid_dropped", 32'(result_valid_o), 32'd0);
        check_output("mixed_start_in_done_ignored", 32'(busy_o), 32'd0);
        tick();
        check_output("mixed_still_idle", 32'(busy_o), 32'd0);

        // Reset mid-ACC discards the run.
        apply_stimulus(ramp, e, 1'b0);
        repeat (15) tick();
        rst = 1'b1;
        #2;
        check_output("midrst_busy", 32'(busy_o), 32'd0);
        check_output("midrst_valid", 32'(result_valid_o), 32'd0);
        check_output("midrst_sum", 32'(sum_o), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (40) tick();
        check_output("midrst_no_stale_valid", 32'(result_valid_o), 32'd0);
        e = '{sum: 21'd496, mx: max_exp(16'd31), idx: idx_exp(5'd31)};
        apply_stimulus(ramp, e, 1'b1);
        check_latency();
        tick();
        tick();

        check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram16_vec_reducer.md
# ram16_vec_reducer

Downstream consumer of the 16-bit scratch RAM's 32 parallel registered read words. On a start pulse it snapshots all 32 words, then walks them one per cycle, producing the signed sum and, optionally, the maximum value and its index. Results are held behind a valid/ready handshake for the core-side reader, so the RAM can be rewritten while reduction is in progress.

## Interface
- WORD_WIDTH, 16, width of each input word (signed two's complement)
- NUM_WORDS, 32, number of parallel words consumed; power of two, ≥2
- SUM_WIDTH, WORD_WIDTH+$clog2(NUM_WORDS), accumulator/sum width (derived, not overridden)
- IDX_WIDTH, $clog2(NUM_WORDS), index width (derived)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- words_i  in  NUM_WORDS*WORD_WIDTH  packed RAM words; word k at [k*WORD_WIDTH +: WORD_WIDTH]
- start_i  in  1  request reduction; honoured only in IDLE
- busy_o  out  1  high in SNAP-free ACC and DONE states (block not accepting start)
- result_valid_o  out  1  result registers valid
- result_ready_i  in  1  consumer accepts result
- sum_o  out  SUM_WIDTH  signed sum of all words
- max_o  out  WORD_WIDTH  signed maximum word
- max_idx_o  out  IDX_WIDTH  index of maximum word

## Operation
- States: IDLE, ACC, DONE (2-bit encoded register).
- IDLE: start_i=1 at edge → copy words_i into snapshot array, clear acc to 0, max to most-negative value, max_idx to 0, idx counter to 0; go ACC. start_i=0 → stay.
- ACC: each edge process snapshot[idx]: acc += sign-extended word; if word > max (strict signed), max←word, max_idx←idx; idx++. After processing idx=NUM_WORDS-1, latch acc/max/max_idx into output registers and go DONE.
- DONE: result_valid_o=1; outputs stable. result_ready_i=1 at edge → IDLE. start_i in DONE ignored (including same cycle as ready).
- start_i in ACC ignored; snapshot never changes during ACC regardless of words_i.
- Arithmetic: sum is exact; SUM_WIDTH guarantees no overflow (range −NUM_WORDS·2^(W−1) … NUM_WORDS·(2^(W−1)−1)). Max ties: lowest index wins.
- idx counter is IDX_WIDTH bits; terminal detection on idx==NUM_WORDS-1, no wrap reliance.
- Reset (any state, including mid-ACC): state IDLE, idx 0, acc 0, snapshot contents don't-care, all outputs reset values; in-flight reduction discarded, no result produced.

## Timing
- Reset values: busy_o=0, result_valid_o=0, sum_o=0, max_o=0, max_idx_o=0.
- start sampled high at edge N → busy_o high after edge N; words processed at edges N+1 … N+NUM_WORDS; result_valid_o high after edge N+NUM_WORDS (latency NUM_WORDS cycles, 32 by default).
- Handshake transfer at edge where result_valid_o=1 and result_ready_i=1; result_valid_o and busy_o low after that edge; next start accepted one cycle later (earliest at the following edge). Minimum start-to-start period NUM_WORDS+2 cycles with ready held high.
- result_ready_i while not valid: no effect.
- Output registers change only on entry to DONE; hold last result after handshake until next DONE.
- words_i sampled only on the start edge; upstream must present RAM outputs settled (RAM read issued at least one cycle earlier).

## Configuration
- REDUCER_MAX_EN defined: max/argmax tracking implemented as above.
- Undefined: max and index registers and comparator omitted; max_o and max_idx_o constant 0 (including reset); sum and timing unchanged.

## Test plan
- Reset, all words 0, start → after 32 cycles valid, sum_o=0, max_o=0, max_idx_o=0.
- Word k = k (0..31), start, ready held high → sum_o=496, max_o=31, max_idx_o=31, valid for exactly one cycle.
- All words 0x8000 → sum_o=−1048576 (21'h100000), max_o=0x8000, max_idx_o=0 (tie rule).
- Words 0x7FFF at k=5 and k=20, rest 1; change words_i every cycle during ACC; ready low 10 cycles after valid → sum_o=65564, max_idx_o=5, outputs stable while valid and not ready; extra start_i pulses ignored.
- Assert rst at cycle 15 of ACC, release, start with ramp → no stale valid; fresh result sum_o=496 after 32 cycles.
- Build without REDUCER_MAX_EN, ramp input → sum_o=496, max_o=0, max_idx_o=0.
